mm_wide_sub: RTL and testbench

MM_WIDE_SUB -- requirements
Module: mm_wide_sub

---
 rtl/mm_wide_sub_pkg.sv | 19 +
 rtl/mm_wide_sub_word_sub_16bit.sv | 48 ++++
 rtl/mm_wide_sub.sv | 92 +++++++++
 tb/tb_mm_wide_sub.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mm_wide_sub_pkg.sv
// Shared definitions for the multi-word subtractor: default geometry,
// counter sizing and FSM state encoding.
package mm_wide_sub_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int NWORDS_DEF = 256;

    // Word counter width; a single-word operand still needs one bit.
    function automatic int cnt_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/mm_wide_sub_word_sub_16bit.sv
// Combinational word subtractor: a + ~b + !bin on a parallel-prefix
// (Kogge-Stone) carry-lookahead network; bout is the inverted carry out.
module word_sub_16bit
    import mm_wide_sub_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic [WORD_W-1:0] diff,
    output logic              bout
);

    logic [WORD_W-1:0] nb;
    logic [WORD_W-1:0] psum;
    logic              cin;
    logic [WORD_W-1:0] g, p, gn, pn;
    logic [WORD_W:0]   c;

    assign nb   = ~b;
    assign cin  = ~bin;
    assign psum = a ^ nb;

    // After the prefix passes g[i] is the carry out of bit i, cin folded in at bit 0.
    always_comb begin
        g    = a & nb;
        p    = psum;
        g[0] = g[0] | (p[0] & cin);
        gn   = g;
        pn   = p;
        for (int d = 1; d < WORD_W; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < WORD_W; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
    end

    assign c    = {g, cin};
    assign diff = psum ^ c[WORD_W-1:0];
    assign bout = ~c[WORD_W];

endmodule

// File: rtl/mm_wide_sub.sv
// Streaming multi-word subtractor A - B, LSW first, one word per cycle with
// a registered valid/ready output stage and final borrow on the last word.
module mm_wide_sub
    import mm_wide_sub_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_diff,
    output logic              out_last,
    output logic              out_borrow,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_w(NWORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              borrow_reg;
    logic [WORD_W-1:0] diff;
    logic              bout;
    logic              accept, out_fire, is_last;

    word_sub_16bit #(.WORD_W(WORD_W)) u_sub (
        .a    (in_a),
        .b    (in_b),
        .bin  (borrow_reg),
        .diff (diff),
        .bout (bout)
    );

    assign in_ready = (state == RUN) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign is_last  = (cnt == LAST_IDX);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && is_last) state_nx = FLUSH;
            FLUSH:   if (out_fire && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_last   <= 1'b0;
            out_borrow <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == FLUSH) & out_fire & out_last;
            if (state == IDLE && start) begin
                cnt        <= '0;
                borrow_reg <= 1'b0;
            end
            // A new word replaces the held one; otherwise a handshake just drains it.
            if (accept) begin
                out_valid  <= 1'b1;
                out_diff   <= diff;
                out_last   <= is_last;
                out_borrow <= is_last & bout;
                borrow_reg <= bout;
                cnt        <= cnt + 1'b1;
            end else if (out_fire) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                out_borrow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mm_wide_sub.sv
// Directed bench for mm_wide_sub with 4 x 16-bit operands.
module tb_mm_wide_sub;

    localparam int WORD_W = 16;
    localparam int NWORDS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_a = '0;
    logic [WORD_W-1:0] in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_diff;
    logic              out_last;
    logic              out_borrow;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;

    mm_wide_sub #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_last   (out_last),
        .out_borrow (out_borrow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one full operation from a negedge; optional random backpressure
    // and a stray start pulse while running.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_d, input logic exp_bo,
                          input bit rnd, input bit mid_start);
        int nin = 0, nout = 0, ndone = 0, stall_bad = 0, last_idx = -1, nonlast_bo = 0;
        logic [63:0] got = '0;
        logic bo = 1'b0;
        logic fi, fo;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int cyc = 0; cyc < 200 && ndone == 0; cyc++) begin
            in_valid  = (nin < NWORDS);
            in_a      = WORD_W'(a >> (WORD_W * nin));
            in_b      = WORD_W'(b >> (WORD_W * nin));
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = mid_start && (cyc == 1);
            #1;
            if (out_valid && !out_ready && in_ready) stall_bad++;
            fi = in_valid & in_ready;
            fo = out_valid & out_ready;
            if (fo) begin
                if (nout < NWORDS) got[nout*WORD_W +: WORD_W] = out_diff;
                if (out_last) begin
                    last_idx = nout;
                    bo = out_borrow;
                end else if (out_borrow) nonlast_bo++;
                nout++;
            end
            if (done) ndone++;
            @(posedge clk);
            if (fi) nin++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (done) ndone++;
            if (out_valid) nout++;
            @(negedge clk);
        end
        check({tag, "_diff"}, got, exp_d);
        check({tag, "_nout"}, 64'(nout), 64'(NWORDS));
        check({tag, "_last_idx"}, 64'(last_idx), 64'(NWORDS - 1));
        check({tag, "_borrow"}, 64'(bo), 64'(exp_bo));
        check({tag, "_nonlast_bo"}, 64'(nonlast_bo), 64'd0);
        check({tag, "_done_cnt"}, 64'(ndone), 64'd1);
        check({tag, "_stall"}, 64'(stall_bad), 64'd0);
        check({tag, "_idle"}, 64'({busy, in_ready, out_valid}), 64'd0);
    endtask

    initial begin
        int n;
        logic fi;
        #1;
        check("rst_outs", 64'({out_valid, out_diff, out_last, out_borrow, done}), 64'd0);
        check("rst_busy", 64'({busy, in_ready}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("borrow_chain", 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001,
               64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("a_lt_b", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
               64'h0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_op("backpress", 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001,
                   64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("mid_start", 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001,
               64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            in_valid  = 1'b1;
            in_a      = 16'h0000;
            in_b      = 16'h0001;
            out_ready = 1'b1;
            #1;
            fi = in_valid & in_ready;
            @(posedge clk);
            if (fi) n++;
            @(negedge clk);
        end
        check("rst_mid_accepted", 64'(n), 64'd2);
        check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 64'({out_valid, out_diff, out_last, out_borrow, done}), 64'd0);
        check("rst_mid_busy", 64'({busy, in_ready}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_still_idle", 64'({busy, out_valid}), 64'd0);
        run_op("after_rst", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
